// File: rtl/execute_pkg.sv
// Shared constants for the LC-3 execute stage: opcodes,
// E_control field layout and the select encodings it carries.
package execute_pkg;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_AND  = 2'b01,
      ALU_NOT  = 2'b10,
      ALU_RSVD = 2'b11
   } alu_ctl_e;

   typedef enum logic [1:0] {
      PC1_OFF11 = 2'b00,
      PC1_OFF9  = 2'b01,
      PC1_OFF6  = 2'b10,
      PC1_ZERO  = 2'b11
   } pcsel1_e;

   localparam logic PC2_NPC = 1'b1;
   localparam logic PC2_REG = 1'b0;
   localparam logic OP2_REG = 1'b1;
   localparam logic OP2_IMM = 1'b0;

   localparam int EC_ALU_HI = 5;
   localparam int EC_ALU_LO = 4;
   localparam int EC_PC1_HI = 3;
   localparam int EC_PC1_LO = 2;
   localparam int EC_PC2    = 1;
   localparam int EC_OP2    = 0;

   function automatic logic [15:0] sext5(input logic [4:0] v);
      return {{11{v[4]}}, v};
   endfunction

   function automatic logic [15:0] sext6(input logic [5:0] v);
      return {{10{v[5]}}, v};
   endfunction

   function automatic logic [15:0] sext9(input logic [8:0] v);
      return {{7{v[8]}}, v};
   endfunction

   function automatic logic [15:0] sext11(input logic [10:0] v);
      return {{5{v[10]}}, v};
   endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational LC-3 ALU: ADD, AND and NOT of operand a.
// Reserved control code yields zero.
module execute_alu
   import execute_pkg::*;
(
   input  alu_ctl_e    alu_control,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] result
);

   always_comb begin
      result = 16'h0000;
      unique case (alu_control)
         ALU_ADD:  result = a + b;
         ALU_AND:  result = a & b;
         ALU_NOT:  result = ~a;
         ALU_RSVD: result = 16'h0000;
      endcase
   end

endmodule

// File: rtl/execute.sv
// LC-3 execute stage: operand forwarding, ALU, address adder,
// branch mask and the registered execute/memory boundary.
module execute
   import execute_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] IR,
   input  logic [15:0] npc_in,
   input  logic [5:0]  E_control,
   input  logic [1:0]  W_control_in,
   input  logic        Mem_control_in,
   input  logic        enable_execute,
   input  logic [15:0] VSR1,
   input  logic [15:0] VSR2,
   input  logic        bypass_alu_1,
   input  logic        bypass_alu_2,
   input  logic        bypass_mem_1,
   input  logic        bypass_mem_2,
   input  logic [15:0] Mem_Bypass_Val,
   output logic [15:0] aluout,
   output logic [15:0] pcout,
   output logic [15:0] M_Data,
   output logic [15:0] IR_Exec,
   output logic [1:0]  W_control_out,
   output logic        Mem_control_out,
   output logic [2:0]  NZP,
   output logic [2:0]  sr1,
   output logic [2:0]  sr2,
   output logic [2:0]  dr
);

   logic [3:0]  opcode;
   alu_ctl_e    alu_control;
   pcsel1_e     pcselect1;
   logic        pcselect2;
   logic        op2select;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [15:0] alu_in2;
   logic [15:0] alu_res;
   logic [15:0] offset;
   logic [15:0] base;
   logic [15:0] addr_res;
   logic [15:0] aluout_d;
   logic [2:0]  nzp_d;

   assign opcode      = IR[15:12];
   assign alu_control = alu_ctl_e'(E_control[EC_ALU_HI:EC_ALU_LO]);
   assign pcselect1   = pcsel1_e'(E_control[EC_PC1_HI:EC_PC1_LO]);
   assign pcselect2   = E_control[EC_PC2];
   assign op2select   = E_control[EC_OP2];

   assign sr1 = IR[8:6];
   assign dr  = IR[11:9];

   always_comb begin
      sr2 = IR[2:0];
      if (opcode == OP_ST || opcode == OP_STR || opcode == OP_STI)
         sr2 = IR[11:9];
   end

   // aluout feedback is the previous instruction's result
   always_comb begin
      op_a = VSR1;
      if (bypass_alu_1)
         op_a = aluout;
      else if (bypass_mem_1)
         op_a = Mem_Bypass_Val;
   end

   always_comb begin
      op_b = VSR2;
      if (bypass_alu_2)
         op_b = aluout;
      else if (bypass_mem_2)
         op_b = Mem_Bypass_Val;
   end

   assign alu_in2 = (op2select == OP2_REG) ? op_b : sext5(IR[4:0]);

   execute_alu u_alu (
      .alu_control (alu_control),
      .a           (op_a),
      .b           (alu_in2),
      .result      (alu_res)
   );

   always_comb begin
      offset = 16'h0000;
      unique case (pcselect1)
         PC1_OFF11: offset = sext11(IR[10:0]);
         PC1_OFF9:  offset = sext9(IR[8:0]);
         PC1_OFF6:  offset = sext6(IR[5:0]);
         PC1_ZERO:  offset = 16'h0000;
      endcase
   end

   assign base     = (pcselect2 == PC2_NPC) ? npc_in : op_a;
   assign addr_res = base + offset;

   always_comb begin
      aluout_d = addr_res;
      if (opcode == OP_ADD || opcode == OP_AND || opcode == OP_NOT)
         aluout_d = alu_res;
   end

   always_comb begin
      nzp_d = 3'b000;
      if (opcode == OP_BR)
         nzp_d = IR[11:9];
      else if (opcode == OP_JMP)
         nzp_d = 3'b111;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         aluout          <= 16'h0000;
         pcout           <= 16'h0000;
         M_Data          <= 16'h0000;
         IR_Exec         <= 16'h0000;
         W_control_out   <= 2'b00;
         Mem_control_out <= 1'b0;
         NZP             <= 3'b000;
      end else if (enable_execute) begin
         aluout          <= aluout_d;
         pcout           <= addr_res;
         M_Data          <= op_b;
         IR_Exec         <= IR;
         W_control_out   <= W_control_in;
         Mem_control_out <= Mem_control_in;
         NZP             <= nzp_d;
      end
   end

endmodule

// File: tb/tb_execute.sv
// Directed-vector bench for the LC-3 execute stage.
// Expected values are hand-computed from the instruction encodings.
module tb_execute;

   logic        clock;
   logic        reset;
   logic [15:0] IR;
   logic [15:0] npc_in;
   logic [5:0]  E_control;
   logic [1:0]  W_control_in;
   logic        Mem_control_in;
   logic        enable_execute;
   logic [15:0] VSR1;
   logic [15:0] VSR2;
   logic        bypass_alu_1;
   logic        bypass_alu_2;
   logic        bypass_mem_1;
   logic        bypass_mem_2;
   logic [15:0] Mem_Bypass_Val;
   logic [15:0] aluout;
   logic [15:0] pcout;
   logic [15:0] M_Data;
   logic [15:0] IR_Exec;
   logic [1:0]  W_control_out;
   logic        Mem_control_out;
   logic [2:0]  NZP;
   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic [2:0]  dr;

   int n_checks = 0;
   int n_fail   = 0;

   execute dut (
      .clock           (clock),
      .reset           (reset),
      .IR              (IR),
      .npc_in          (npc_in),
      .E_control       (E_control),
      .W_control_in    (W_control_in),
      .Mem_control_in  (Mem_control_in),
      .enable_execute  (enable_execute),
      .VSR1            (VSR1),
      .VSR2            (VSR2),
      .bypass_alu_1    (bypass_alu_1),
      .bypass_alu_2    (bypass_alu_2),
      .bypass_mem_1    (bypass_mem_1),
      .bypass_mem_2    (bypass_mem_2),
      .Mem_Bypass_Val  (Mem_Bypass_Val),
      .aluout          (aluout),
      .pcout           (pcout),
      .M_Data          (M_Data),
      .IR_Exec         (IR_Exec),
      .W_control_out   (W_control_out),
      .Mem_control_out (Mem_control_out),
      .NZP             (NZP),
      .sr1             (sr1),
      .sr2             (sr2),
      .dr              (dr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag,
                        input logic [15:0] got,
                        input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // E_control = {alu_control, pcselect1, pcselect2, op2select}
   task automatic set_ec(input logic [1:0] alu, input logic [1:0] ps1,
                         input logic ps2, input logic op2);
      E_control = {alu, ps1, ps2, op2};
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".aluout"}, aluout, 16'h0000);
      check({tag, ".pcout"},  pcout,  16'h0000);
      check({tag, ".M_Data"}, M_Data, 16'h0000);
      check({tag, ".IR_Exec"}, IR_Exec, 16'h0000);
      check({tag, ".W_ctl"}, {14'h0, W_control_out}, 16'h0000);
      check({tag, ".Mem_ctl"}, {15'h0, Mem_control_out}, 16'h0000);
      check({tag, ".NZP"}, {13'h0, NZP}, 16'h0000);
   endtask

   initial begin
      reset          = 1'b1;
      IR             = 16'h0000;
      npc_in         = 16'h0000;
      E_control      = 6'h00;
      W_control_in   = 2'b00;
      Mem_control_in = 1'b0;
      enable_execute = 1'b1;
      VSR1           = 16'h0000;
      VSR2           = 16'h0000;
      bypass_alu_1   = 1'b0;
      bypass_alu_2   = 1'b0;
      bypass_mem_1   = 1'b0;
      bypass_mem_2   = 1'b0;
      Mem_Bypass_Val = 16'h0000;

      repeat (2) tick();
      check_all_zero("rst");
      reset = 1'b0;

      // ADD R0,R1,#5
      IR = 16'h1065; VSR1 = 16'h0003; VSR2 = 16'h7777;
      npc_in = 16'h3000; W_control_in = 2'b01;
      set_ec(2'b00, 2'b00, 1'b0, 1'b0);
      #1;
      check("add.sr1", {13'h0, sr1}, 16'h0001);
      check("add.dr",  {13'h0, dr},  16'h0000);
      check("add.sr2", {13'h0, sr2}, 16'h0005);
      tick();
      check("add.aluout", aluout, 16'h0008);
      check("add.NZP", {13'h0, NZP}, 16'h0000);
      check("add.IR_Exec", IR_Exec, 16'h1065);
      check("add.W_ctl", {14'h0, W_control_out}, 16'h0001);

      // ADD R0,R1,#-1
      IR = 16'h107F; VSR1 = 16'h0010;
      tick();
      check("addneg.aluout", aluout, 16'h000F);

      // produce 0x00FF, then AND R0,R0,R1 forwarding it
      IR = 16'h1065; VSR1 = 16'h00FA;
      tick();
      check("fwd.prev", aluout, 16'h00FF);
      IR = 16'h5001; VSR1 = 16'hFFFF; VSR2 = 16'h0F0F;
      bypass_alu_1 = 1'b1;
      set_ec(2'b01, 2'b00, 1'b0, 1'b1);
      tick();
      check("fwd.and", aluout, 16'h000F);
      bypass_alu_1 = 1'b0;

      // NOT R0,R1
      IR = 16'h907F; VSR1 = 16'h1234;
      set_ec(2'b10, 2'b00, 1'b0, 1'b1);
      tick();
      check("not.aluout", aluout, 16'hEDCB);

      // ADD R0,R1,R2 with both _2 selects: alu forward wins
      IR = 16'h1042; VSR1 = 16'h0001; VSR2 = 16'h5A5A;
      Mem_Bypass_Val = 16'h1000;
      bypass_alu_2 = 1'b1; bypass_mem_2 = 1'b1;
      set_ec(2'b00, 2'b00, 1'b0, 1'b1);
      tick();
      check("prio.aluout", aluout, 16'hEDCC);
      check("prio.M_Data", M_Data, 16'hEDCB);
      bypass_alu_2 = 1'b0; bypass_mem_2 = 1'b0;

      // BRnp +5
      IR = 16'h0A05; npc_in = 16'h3001;
      set_ec(2'b00, 2'b01, 1'b1, 1'b0);
      tick();
      check("br.pcout", pcout, 16'h3006);
      check("br.NZP", {13'h0, NZP}, 16'h0005);
      check("br.aluout", aluout, 16'h3006);

      // STR R2,R1,#2 with memory forwarding of store data
      IR = 16'h7442; VSR1 = 16'h4000; VSR2 = 16'h1111;
      Mem_Bypass_Val = 16'hBEEF; bypass_mem_2 = 1'b1;
      Mem_control_in = 1'b1; W_control_in = 2'b00;
      set_ec(2'b00, 2'b10, 1'b0, 1'b1);
      #1;
      check("str.sr2", {13'h0, sr2}, 16'h0002);
      check("str.sr1", {13'h0, sr1}, 16'h0001);
      tick();
      check("str.M_Data", M_Data, 16'hBEEF);
      check("str.pcout", pcout, 16'h4002);
      check("str.Mem_ctl", {15'h0, Mem_control_out}, 16'h0001);
      check("str.NZP", {13'h0, NZP}, 16'h0000);
      bypass_mem_2 = 1'b0;

      // JMP R7
      IR = 16'hC1C0; VSR1 = 16'h5555; VSR2 = 16'h2222;
      Mem_control_in = 1'b0; W_control_in = 2'b10;
      set_ec(2'b00, 2'b11, 1'b0, 1'b0);
      tick();
      check("jmp.pcout", pcout, 16'h5555);
      check("jmp.NZP", {13'h0, NZP}, 16'h0007);
      check("jmp.aluout", aluout, 16'h5555);

      // stall: outputs hold, register addresses follow IR
      enable_execute = 1'b0;
      IR = 16'h1AC3; VSR1 = 16'h0F00; VSR2 = 16'h00F0;
      npc_in = 16'h9999; W_control_in = 2'b11; Mem_control_in = 1'b1;
      set_ec(2'b01, 2'b01, 1'b1, 1'b1);
      #1;
      check("stall.sr1", {13'h0, sr1}, 16'h0003);
      check("stall.dr",  {13'h0, dr},  16'h0005);
      check("stall.sr2", {13'h0, sr2}, 16'h0003);
      tick();
      IR = 16'h3E00;
      #1;
      check("stall.st_sr2", {13'h0, sr2}, 16'h0007);
      tick();
      tick();
      check("stall.aluout", aluout, 16'h5555);
      check("stall.pcout", pcout, 16'h5555);
      check("stall.M_Data", M_Data, 16'h2222);
      check("stall.IR_Exec", IR_Exec, 16'hC1C0);
      check("stall.W_ctl", {14'h0, W_control_out}, 16'h0002);
      check("stall.Mem_ctl", {15'h0, Mem_control_out}, 16'h0000);
      check("stall.NZP", {13'h0, NZP}, 16'h0007);

      // reset mid-op with a valid enabled ADD in flight
      enable_execute = 1'b1;
      IR = 16'h1065; VSR1 = 16'h0003; Mem_control_in = 1'b0;
      W_control_in = 2'b01;
      set_ec(2'b00, 2'b00, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check_all_zero("rstmid");
      tick();
      check("rstedge.aluout", aluout, 16'h0000);
      check("rstedge.IR_Exec", IR_Exec, 16'h0000);
      reset = 1'b0;
      tick();
      check("post.aluout", aluout, 16'h0008);
      check("post.IR_Exec", IR_Exec, 16'h1065);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
